// File: rtl/seg_display_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
package seg_pkg;

   // All segments dark (active-low drive).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      logic [6:0] seg;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Leading-zero mask bit for digit idx: set when this digit and every
   // digit above it are zero. Values are zero-padded to 16 digits, so the
   // padding never blocks suppression. Digit 0 is excluded by the caller.
   function automatic logic lz_mask_bit(input logic [63:0] val, input int unsigned idx);
      return (val >> (4 * idx)) == 64'd0;
   endfunction

endpackage

// File: rtl/seg_display_scanner_bto7s.sv
// Hex-to-seven-segment decoder (active-low segments).
module bto7s
   import seg_pkg::*;
(
   input  logic [3:0] hex_in,
   output logic [6:0] seg_out
);

   // Pure table lookup.
   always_comb seg_out = hex_to_seg(hex_in);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed seven-segment scanner with frame-synchronous updates,
// per-digit blanking/decimal point, leading-zero suppression and PWM dimming.
module seg_display_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int COUNT_TO   = 100_000,
   parameter int BRIGHT_W   = 4
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress_in,
   input  logic                    load_in,
   input  logic [BRIGHT_W-1:0]     brightness_in,
   output logic                    busy_out,
   output logic                    frame_out,
   output logic [6:0]              cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out
);

   localparam int CNT_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic                    pend_lz_q, pend_lz_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [NUM_DIGITS-1:0]   lz_mask_q, lz_mask_d;
   logic [6:0]              cat_q, cat_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_q, frame_d;

   logic                    boundary;
   logic [3:0]              nibble;
   logic [6:0]              seg;

   // Dwell counter, digit index and free-running PWM counter.
   always_comb begin
      boundary = 1'b0;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      pwm_d    = pwm_q + 1'b1;
      if (cnt_q == CNT_W'(COUNT_TO)) begin
         cnt_d = '0;
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d    = '0;
            boundary = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Pending/active register sets; a load on the boundary bypasses pending.
   always_comb begin
      logic [4*NUM_DIGITS-1:0] src_val;
      logic [NUM_DIGITS-1:0]   src_dp, src_blank;
      logic                    src_lz;
      logic [63:0]             src_pad;

      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_lz_d    = pend_lz_q;
      pend_valid_d = pend_valid_q;
      act_val_d    = act_val_q;
      act_dp_d     = act_dp_q;
      act_blank_d  = act_blank_q;
      lz_mask_d    = lz_mask_q;

      src_val   = load_in ? val_in         : pend_val_q;
      src_dp    = load_in ? dp_in          : pend_dp_q;
      src_blank = load_in ? blank_in       : pend_blank_q;
      src_lz    = load_in ? lz_suppress_in : pend_lz_q;
      src_pad   = '0;
      src_pad[4*NUM_DIGITS-1:0] = src_val;

      if (load_in) begin
         pend_val_d   = val_in;
         pend_dp_d    = dp_in;
         pend_blank_d = blank_in;
         pend_lz_d    = lz_suppress_in;
         pend_valid_d = 1'b1;
      end

      if (boundary) begin
         pend_valid_d = 1'b0;
         if (load_in || pend_valid_q) begin
            act_val_d    = src_val;
            act_dp_d     = src_dp;
            act_blank_d  = src_blank;
            lz_mask_d    = '0;
            for (int i = 1; i < NUM_DIGITS; i++) begin
               lz_mask_d[i] = src_lz & lz_mask_bit(src_pad, i);
            end
         end
      end
   end

   bto7s u_bto7s (
      .hex_in  (nibble),
      .seg_out (seg)
   );

   // Next registered pin drive from the current digit, mask and PWM phase.
   always_comb begin
      logic dark;
      logic pwm_on;

      nibble = act_val_q[4*idx_q +: 4];
      dark   = act_blank_q[idx_q] | lz_mask_q[idx_q];
      pwm_on = (brightness_in == '1) || (pwm_q < brightness_in);

      an_d = '1;
      if (!dark && pwm_on) an_d[idx_q] = 1'b0;
      cat_d   = dark ? SEG_OFF : seg;
      dp_d    = dark | ~act_dp_q[idx_q];
      frame_d = boundary;
   end

   // State and output registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_lz_q    <= 1'b0;
         pend_valid_q <= 1'b0;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         lz_mask_q    <= '0;
         cat_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_lz_q    <= pend_lz_d;
         pend_valid_q <= pend_valid_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         lz_mask_q    <= lz_mask_d;
         cat_q        <= cat_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_q      <= frame_d;
      end
   end

   assign busy_out  = pending_flag();
   assign frame_out = frame_q;
   assign cat_out   = cat_q;
   assign dp_out    = dp_q;
   assign an_out    = an_q;

   function automatic logic pending_flag();
      return pend_valid_q;
   endfunction

endmodule
